// File: rtl/w_stage_grf_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// w_stage_grf_if : M/W writeback bundle plus D-stage register read ports
// Revision 1.0
// ---------------------------------------------------------------------------
interface w_stage_grf_if;
  logic        RegWriteW;
  logic [1:0]  MemtoRegW;
  logic [2:0]  LoadopW;
  logic [31:0] RDW;
  logic [31:0] ALUoutW;
  logic [31:0] PC_4W;
  logic [4:0]  AwriteW;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic [31:0] WD_W;
  logic        WE_W;

  modport master (
    output RegWriteW, MemtoRegW, LoadopW, RDW, ALUoutW, PC_4W, AwriteW, A1, A2,
    input  RD1, RD2, WD_W, WE_W
  );

  modport slave (
    input  RegWriteW, MemtoRegW, LoadopW, RDW, ALUoutW, PC_4W, AwriteW, A1, A2,
    output RD1, RD2, WD_W, WE_W
  );
endinterface
`default_nettype wire

// File: rtl/w_stage_grf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// w_stage_grf : writeback select, load extension and 32x32 GRF with bypass
// Revision 1.0
// ---------------------------------------------------------------------------
module w_stage_grf (
  input  logic          clk,
  input  logic          reset,
  w_stage_grf_if.slave  bus
);

  logic [31:0] regs_q [32];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [31:0] wd;
  logic        we;
  logic [31:0] rd1;
  logic [31:0] rd2;

  always_comb begin
    byte_sel  = 8'h00;
    half_sel  = 16'h0000;
    load_data = bus.RDW;
    wd        = 32'd0;

    case (bus.ALUoutW[1:0])
      2'd0:    byte_sel = bus.RDW[7:0];
      2'd1:    byte_sel = bus.RDW[15:8];
      2'd2:    byte_sel = bus.RDW[23:16];
      default: byte_sel = bus.RDW[31:24];
    endcase
    // Halfword alignment only looks at bit 1; bit 0 is ignored.
    half_sel = bus.ALUoutW[1] ? bus.RDW[31:16] : bus.RDW[15:0];

    case (bus.LoadopW)
      3'd1:    load_data = {24'd0, byte_sel};
      3'd2:    load_data = {{24{byte_sel[7]}}, byte_sel};
      3'd3:    load_data = {16'd0, half_sel};
      3'd4:    load_data = {{16{half_sel[15]}}, half_sel};
      default: load_data = bus.RDW;
    endcase

    case (bus.MemtoRegW)
      2'b00:   wd = bus.ALUoutW;
      2'b01:   wd = load_data;
      2'b10:   wd = bus.PC_4W + 32'd4;
      default: wd = 32'd0;
    endcase
  end

  assign we = bus.RegWriteW & (bus.AwriteW != 5'd0) & reset;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'd0;
      end
    end else if (we) begin
      regs_q[bus.AwriteW] <= wd;
    end
  end

  // Same-cycle write-through so D sees the W result without a stall.
  always_comb begin
    rd1 = 32'd0;
    rd2 = 32'd0;
    if (bus.A1 == 5'd0)                     rd1 = 32'd0;
    else if (we && (bus.A1 == bus.AwriteW)) rd1 = wd;
    else                                    rd1 = regs_q[bus.A1];
    if (bus.A2 == 5'd0)                     rd2 = 32'd0;
    else if (we && (bus.A2 == bus.AwriteW)) rd2 = wd;
    else                                    rd2 = regs_q[bus.A2];
  end

  assign bus.RD1  = rd1;
  assign bus.RD2  = rd2;
  assign bus.WD_W = wd;
  assign bus.WE_W = we;

endmodule
`default_nettype wire

// File: tb/tb_w_stage_grf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_w_stage_grf : directed vectors checked against a behavioural GRF model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_w_stage_grf;

  logic clk;
  logic reset;
  logic en;
  int   errors;
  int   checks;
  logic [31:0] mregs [32];

  w_stage_grf_if bus ();

  w_stage_grf dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_wd(input logic [1:0] mtr, input logic [2:0] op,
                                           input logic [31:0] rdw, input logic [31:0] alu,
                                           input logic [31:0] pc);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] ld;
    b = 8'(rdw >> (8 * alu[1:0]));
    h = 16'(rdw >> (16 * alu[1]));
    case (op)
      3'd1:    ld = 32'(b);
      3'd2:    ld = 32'($signed(b));
      3'd3:    ld = 32'(h);
      3'd4:    ld = 32'($signed(h));
      default: ld = rdw;
    endcase
    case (mtr)
      2'b00:   return alu;
      2'b01:   return ld;
      2'b10:   return pc + 32'd4;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rw, input logic [1:0] mtr, input logic [2:0] op,
                       input logic [31:0] rdw, input logic [31:0] alu, input logic [31:0] pc,
                       input logic [4:0] aw, input logic [4:0] a1, input logic [4:0] a2);
    bus.RegWriteW = rw;
    bus.MemtoRegW = mtr;
    bus.LoadopW   = op;
    bus.RDW       = rdw;
    bus.ALUoutW   = alu;
    bus.PC_4W     = pc;
    bus.AwriteW   = aw;
    bus.A1        = a1;
    bus.A2        = a2;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Architectural model: array state updated on each edge.
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    end else if (bus.RegWriteW && bus.AwriteW != 5'd0) begin
      mregs[bus.AwriteW] = model_wd(bus.MemtoRegW, bus.LoadopW, bus.RDW, bus.ALUoutW, bus.PC_4W);
    end
  end

  always @(negedge clk) begin
    if (en) begin
      logic        ew;
      logic [31:0] ewd;
      logic [31:0] e1;
      logic [31:0] e2;
      ew  = bus.RegWriteW && (bus.AwriteW != 5'd0) && reset;
      ewd = model_wd(bus.MemtoRegW, bus.LoadopW, bus.RDW, bus.ALUoutW, bus.PC_4W);
      e1  = (bus.A1 == 5'd0) ? 32'd0 : (ew && bus.A1 == bus.AwriteW) ? ewd : mregs[bus.A1];
      e2  = (bus.A2 == 5'd0) ? 32'd0 : (ew && bus.A2 == bus.AwriteW) ? ewd : mregs[bus.A2];
      check("model_WE_W", 32'(bus.WE_W), 32'(ew));
      check("model_WD_W", bus.WD_W, ewd);
      check("model_RD1", bus.RD1, e1);
      check("model_RD2", bus.RD2, e2);
    end
  end

  logic [2:0]  ld_op  [6] = '{3'd2, 3'd1, 3'd4, 3'd3, 3'd0, 3'd5};
  logic [31:0] ld_adr [6] = '{32'h0000_1003, 32'h0000_1000, 32'h0000_1001,
                              32'h0000_1002, 32'h0000_1000, 32'h0000_1003};
  logic [31:0] ld_exp [6] = '{32'hFFFF_FF88, 32'h0000_00BB, 32'hFFFF_AABB,
                              32'h0000_8899, 32'h8899_AABB, 32'h8899_AABB};

  initial begin
    errors = 0;
    checks = 0;
    en     = 1'b0;
    reset  = 1'b0;
    drive(0, 2'b00, 3'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    en    = 1'b1;
    @(negedge clk);
    check("reset_RD1", bus.RD1, 32'd0);

    // Write r5, then reset with a write still pending in W.
    drive(1, 2'b00, 3'd0, 32'd0, 32'h1234_5678, 32'd0, 5'd5, 5'd5, 5'd0);
    @(negedge clk);
    check("r5_bypass", bus.RD1, 32'h1234_5678);
    next_cycle();
    reset = 1'b0;
    drive(1, 2'b00, 3'd0, 32'd0, 32'hAAAA_5555, 32'd0, 5'd5, 5'd5, 5'd5);
    @(negedge clk);
    check("reset_WE_W", 32'(bus.WE_W), 32'd0);
    check("r5_before_clear", bus.RD1, 32'h1234_5678);
    next_cycle();
    @(negedge clk);
    check("r5_cleared", bus.RD1, 32'd0);
    check("reset_WE_W_2", 32'(bus.WE_W), 32'd0);
    next_cycle();
    reset = 1'b1;
    drive(0, 2'b00, 3'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd0);
    @(negedge clk);
    check("r5_after_reset", bus.RD1, 32'd0);

    // Write/bypass to r8.
    next_cycle();
    drive(1, 2'b00, 3'd0, 32'd0, 32'hDEAD_BEEF, 32'd0, 5'd8, 5'd8, 5'd0);
    @(negedge clk);
    check("r8_bypass", bus.RD1, 32'hDEAD_BEEF);
    next_cycle();
    drive(0, 2'b00, 3'd0, 32'd0, 32'd0, 32'd0, 5'd8, 5'd8, 5'd0);
    @(negedge clk);
    check("r8_array", bus.RD1, 32'hDEAD_BEEF);

    // $0 guard.
    next_cycle();
    drive(1, 2'b00, 3'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    check("r0_RD1", bus.RD1, 32'd0);
    check("r0_RD2", bus.RD2, 32'd0);
    check("r0_WE_W", 32'(bus.WE_W), 32'd0);
    next_cycle();
    drive(0, 2'b00, 3'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    check("r0_after", bus.RD1, 32'd0);

    // Loads into r10, read back through both bypass and array.
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      drive(1, 2'b01, ld_op[i], 32'h8899_AABB, ld_adr[i], 32'd0, 5'd10, 5'd10, 5'd8);
      @(negedge clk);
      check("load_WD_W", bus.WD_W, ld_exp[i]);
      next_cycle();
      drive(0, 2'b00, 3'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd10, 5'd0);
      @(negedge clk);
      check("load_array", bus.RD1, ld_exp[i]);
    end

    // Link address into r31.
    next_cycle();
    drive(1, 2'b10, 3'd0, 32'd0, 32'd0, 32'h0000_3004, 5'd31, 5'd0, 5'd0);
    @(negedge clk);
    check("link_WD_W", bus.WD_W, 32'h0000_3008);
    next_cycle();
    drive(0, 2'b11, 3'd0, 32'd0, 32'h1111_2222, 32'd0, 5'd0, 5'd31, 5'd0);
    @(negedge clk);
    check("link_array", bus.RD1, 32'h0000_3008);
    check("sel11_WD_W", bus.WD_W, 32'd0);

    // Back-to-back writes to r3 with both ports aimed at it.
    next_cycle();
    drive(1, 2'b00, 3'd0, 32'd0, 32'd1, 32'd0, 5'd3, 5'd3, 5'd3);
    @(negedge clk);
    check("b2b_RD2_1", bus.RD2, 32'd1);
    check("b2b_RD1_1", bus.RD1, 32'd1);
    next_cycle();
    drive(1, 2'b00, 3'd0, 32'd0, 32'd2, 32'd0, 5'd3, 5'd3, 5'd3);
    @(negedge clk);
    check("b2b_RD2_2", bus.RD2, 32'd2);
    next_cycle();
    drive(0, 2'b00, 3'd0, 32'd0, 32'd0, 32'd0, 5'd3, 5'd8, 5'd3);
    @(negedge clk);
    check("b2b_RD2_array", bus.RD2, 32'd2);
    check("r8_kept", bus.RD1, 32'hDEAD_BEEF);

    next_cycle();
    en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/w_stage_grf.md
# w_stage_grf

Writeback stage and general register file of the 5-stage MIPS pipeline, fed directly by the M/W pipeline register. It performs load-data extension, selects the writeback value and writes the 32x32 register file on the clock edge. It serves the D-stage read ports with internal write-through bypass and exposes the W-stage result for forwarding into D/E/M.

## Interface
- No parameters. Widths are fixed: 32-bit data and 5-bit register addresses.
- clk  in  1  pipeline clock; all state updates on posedge.
- reset  in  1  synchronous, active-low; 0 at a posedge clears the register file.
- RegWriteW  in  1  instruction in W writes a register.
- MemtoRegW  in  2  writeback select:
  - 00 = ALUoutW
  - 01 = extended load data
  - 10 = PC_4W+4 (link address)
  - 11 = 32'd0
- LoadopW  in  3  load extension:
  - 000 = word
  - 001 = lbu
  - 010 = lb
  - 011 = lhu
  - 100 = lh
  - 101-111 = word
- RDW  in  32  raw data-memory word.
- ALUoutW  in  32  ALU result / memory address; bits [1:0] select byte/half.
- PC_4W  in  32  PC+4 of the W instruction.
- AwriteW  in  5  destination register.
- A1, A2  in  5  D-stage read addresses.
- RD1, RD2  out  32  read data (combinational).
- WD_W  out  32  final writeback value (combinational, for forwarding).
- WE_W  out  1  effective write enable = RegWriteW & (AwriteW!=0) & reset.

## Operation
- Load extension (little-endian):
  - byte k = RDW[8k+7:8k], k = ALUoutW[1:0].
  - half = RDW[15:0] if ALUoutW[1]==0, else RDW[31:16]; ALUoutW[0] is ignored for halves.
  - lb/lh sign-extend; lbu/lhu zero-extend; word passes RDW unchanged.
- WD_W is the MemtoRegW-selected value; it is valid whenever the inputs are stable, regardless of WE_W.
- Register file: 32 entries.
  - At posedge with WE_W=1, reg[AwriteW] <= WD_W.
  - reg[0] is never written and always reads 0.
- Read path:
  - RDn = 0 if An==0.
  - Otherwise RDn = WD_W if WE_W=1 and An==AwriteW (write-through bypass).
  - Otherwise RDn = reg[An].
- Reset: while reset=0, every posedge sets all 32 entries to 0.
  - WE_W=0 for the whole assertion, so there is no write and no bypass.
  - RD1/RD2 return stored values, which are 0 after the first reset edge.
- A flushed/bubble M/W (all zeros) gives WE_W=0, a no-op.

## Timing
- Write latency: a value is in the array after the posedge that ends the W cycle, and is readable from the array in the next cycle.
- In the same cycle the value is readable via bypass with zero latency.
- WD_W, WE_W, RD1 and RD2 are purely combinational from inputs and array state; there are no output registers.
- Reset values after the first reset edge:
  - array all 0.
  - RD1 = RD2 = 0.
  - WE_W = 0 while reset=0.
  - WD_W follows its inputs.
- Simultaneous events:
  - A1==A2==AwriteW with WE_W=1: both ports return WD_W.
  - AwriteW==0 with RegWriteW=1: no write, no bypass, reads of $0 return 0.
  - Reset deasserted at a posedge where a write is pending: that edge still clears; the write is lost.
  - A write on the first edge after deassertion succeeds.
- Reset mid-stream: the array clears even if an instruction was in W; no partial writes.

## Test plan
- Reset: hold reset=0 for 2 cycles after writing reg[5]=32'h1234_5678. Required: RD1(A1=5)=0, and WE_W=0 during reset.
- Write/bypass: RegWriteW=1, MemtoRegW=00, AwriteW=8, ALUoutW=32'hDEAD_BEEF, A1=8. Required: RD1=DEADBEEF in the same cycle (bypass) and in the next cycle from the array (with RegWriteW=0).
- $0 guard: RegWriteW=1, AwriteW=0, ALUoutW=32'hFFFF_FFFF, A1=A2=0. Required: RD1=RD2=0, WE_W=0; after the edge RD1 is still 0.
- Loads, all with RDW=32'h8899_AABB:
  - lb, addr[1:0]=3: WD=32'hFFFF_FF88.
  - lbu, addr[1:0]=0: WD=32'h0000_00BB.
  - lh, addr[1]=0: WD=32'hFFFF_AABB.
  - lhu, addr[1]=1: WD=32'h0000_8899.
  - lw: WD=32'h8899_AABB.
- Link: MemtoRegW=10, PC_4W=32'h0000_3004, AwriteW=31. Required: WD_W=32'h0000_3008, and reg[31]=32'h0000_3008 next cycle.
- Back-to-back: write r3=1 then r3=2 on consecutive cycles, with A2=3 held. Required: RD2 reads 1 then 2 via bypass, and 2 afterwards.
